// File: rtl/bcd_stopwatch_pkg.sv
// Shared constants, FSM state type and width helper for the BCD stopwatch.
package bcd_stopwatch_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1 (value >= 2).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control/status bundle between the board-side controller and the stopwatch.
interface bcd_stopwatch_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  run_toggle;
    logic                  clear;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_bcd;
    logic                  lap;
    logic [4*DIGITS-1:0]   bcd;
    logic [4*DIGITS-1:0]   lap_bcd;
    logic                  running;
    logic                  tick;
    logic                  terminal;

    modport master (
        output run_toggle, clear, up_dn, load, load_bcd, lap,
        input  bcd, lap_bcd, running, tick, terminal
    );

    modport slave (
        input  run_toggle, clear, up_dn, load, load_bcd, lap,
        output bcd, lap_bcd, running, tick, terminal
    );
endinterface

// File: rtl/bcd_stopwatch_digit.sv
// One BCD digit: clear > load (clamped to 9) > enabled up/down step with roll-over.
module bcd_digit
    import bcd_stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       up_dn,
    output logic [3:0] digit,
    output logic       at_max,
    output logic       at_min
);

    logic [3:0] digit_q;

    // Digit register; a non-BCD load nibble saturates to 9.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q <= '0;
        end else if (clear) begin
            digit_q <= BCD_MIN;
        end else if (load) begin
            digit_q <= (load_val > BCD_MAX) ? BCD_MAX : load_val;
        end else if (en) begin
            if (up_dn) begin
                digit_q <= (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_q <= (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    assign digit  = digit_q;
    assign at_max = (digit_q == BCD_MAX);
    assign at_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD up/down stopwatch with prescaler tick, wrap/saturate, load and lap.
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIVIDE = 50000000,
    parameter bit          WRAP   = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    bcd_stopwatch_if.slave sw
);

    localparam int unsigned    PW         = clog2(DIVIDE);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIVIDE - 1);

    state_t               state_q, state_d;
    logic [PW-1:0]        presc_q;
    logic [4*DIGITS-1:0]  bcd_w;
    logic [4*DIGITS-1:0]  lap_q;
    logic                 running_q;
    logic                 tick_q;
    logic                 term_q;
    logic [DIGITS-1:0]    at_max;
    logic [DIGITS-1:0]    at_min;
    logic [DIGITS-1:0]    carry;
    logic                 presc_end;
    logic                 advance;
    logic                 all_end;
    logic                 end_evt;
    logic                 sat_evt;

    // A tick is lost to clear/load on the same cycle (they take priority).
    assign presc_end = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
    assign advance   = presc_end && !sw.clear && !sw.load;
    assign all_end   = sw.up_dn ? (&at_max) : (&at_min);
    assign end_evt   = advance && all_end;
    assign sat_evt   = end_evt && !WRAP;

    // Saturation suppresses the cascade so the count holds at the range end.
    assign carry[0]  = advance && !sat_evt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .clear    (sw.clear),
            .load     (sw.load),
            .load_val (sw.load_bcd[4*i +: 4]),
            .en       (carry[i]),
            .up_dn    (sw.up_dn),
            .digit    (bcd_w[4*i +: 4]),
            .at_max   (at_max[i]),
            .at_min   (at_min[i])
        );
        if (i < DIGITS - 1) begin : g_carry
            assign carry[i+1] = carry[i] && (sw.up_dn ? at_max[i] : at_min[i]);
        end
    end

    // Next-state logic: clear dominates, then saturation, then run_toggle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOPPED: begin
                if (!sw.clear && sw.run_toggle) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (sw.clear)           state_d = ST_STOPPED;
                else if (sat_evt)       state_d = ST_DONE;
                else if (sw.run_toggle) state_d = ST_STOPPED;
            end
            ST_DONE: begin
                if (sw.clear || sw.load)           state_d = ST_STOPPED;
                else if (sw.run_toggle && !all_end) state_d = ST_RUNNING;
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // State register with registered running flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUNNING);
        end
    end

    // Prescaler advances only while running, so a pause keeps the partial period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (sw.clear) begin
            presc_q <= '0;
        end else if (state_q == ST_RUNNING) begin
            presc_q <= presc_end ? '0 : presc_q + PW'(1);
        end
    end

    // Registered tick/terminal pulses, aligned with the count update edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
            term_q <= 1'b0;
        end else begin
            tick_q <= advance;
            term_q <= end_evt;
        end
    end

    // Lap captures the count as it stood before this edge; clear leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q <= '0;
        end else if (sw.lap) begin
            lap_q <= bcd_w;
        end
    end

    assign sw.bcd      = bcd_w;
    assign sw.lap_bcd  = lap_q;
    assign sw.running  = running_q;
    assign sw.tick     = tick_q;
    assign sw.terminal = term_q;

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Parametrised multi-digit BCD up/down stopwatch and timer: next generation of the single-digit 1-to-9 seconds watch.
- Generalised in digit count, tick rate, count direction and wrap/saturate mode; adds start/stop, clear, preset load and lap capture.
- Single clock domain: the prescaler produces a one-cycle tick enable, never a derived clock.
- Sits between the board clock/KEY inputs and per-digit hex-to-seven-segment decoders.

Parameters:
- DIGITS, 4, number of BCD digits; count range 0 to 10^DIGITS-1.
- DIVIDE, 50000000, clk cycles per count tick (50 MHz -> 1 Hz); minimum 2.
- WRAP, 1, 1 = wrap at range ends; 0 = saturate and stop.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low; all state cleared.
- run_toggle  input  1  one-cycle pulse; toggles stopped/running.
- clear  input  1  one-cycle pulse; synchronous zero of count and prescaler, forces stopped.
- up_dn  input  1  1 = count up, 0 = count down; sampled on each tick.
- load  input  1  one-cycle pulse; preset count from load_bcd.
- load_bcd  input  4*DIGITS  preset value, digit 0 in [3:0].
- lap  input  1  one-cycle pulse; capture count into lap_bcd.
- bcd  output  4*DIGITS  current count, digit 0 in [3:0].
- lap_bcd  output  4*DIGITS  last captured count.
- running  output  1  high in RUNNING state.
- tick  output  1  one-cycle pulse on the cycle the count advances.
- terminal  output  1  one-cycle pulse when the count wraps or saturates.

Behaviour:
- Reset (reset=0, asynchronous): bcd=0, lap_bcd=0, prescaler=0, state STOPPED, running=0, tick=0, terminal=0.
- FSM states:
  - STOPPED: run_toggle -> RUNNING.
  - RUNNING: run_toggle -> STOPPED; saturation event -> DONE.
  - DONE: run_toggle -> RUNNING only if the count is not at the end matching the current up_dn, otherwise stays DONE; clear or load -> STOPPED.
- running=1 only in RUNNING.
- Prescaler: runs 0..DIVIDE-1 only while RUNNING and holds its value while STOPPED, so pause/resume does not restart the partial second.
- Tick: at prescaler==DIVIDE-1 in RUNNING, the prescaler goes to 0 and the count advances on that edge; tick is registered high for that cycle only. First tick comes DIVIDE cycles after entering RUNNING from a zeroed prescaler.
- BCD cascade, up: digit i increments iff all lower digits ==9; a 9 rolls to 0.
- BCD cascade, down: digit i decrements iff all lower digits ==0; a 0 rolls to 9.
- Up from all-9s: WRAP=1 -> all-0s, terminal=1. WRAP=0 -> hold all-9s, terminal=1, go DONE.
- Down from all-0s: WRAP=1 -> all-9s, terminal=1. WRAP=0 -> hold all-0s, terminal=1, go DONE.
- Load: bcd<=load_bcd, with any nibble >9 clamped to 9. Prescaler and running state are unaffected, except DONE->STOPPED.
- Lap: lap_bcd<=bcd value visible before the edge; a tick on the same cycle does not affect the captured value.
- Priority on the same cycle: clear > load > tick advance. run_toggle is evaluated alongside these but is overridden by clear (clear forces STOPPED).
- clear has no effect on lap_bcd.
- All outputs registered; count latency 0 cycles after the tick edge (bcd updates on the same edge that tick rises).

Decomposition:
- Shared package: BCD_MAX=4'd9 and BCD_MIN=4'd0 constants, state encodings ST_STOPPED/ST_RUNNING/ST_DONE, and a clog2 function for the prescaler width.
- One sub-module bcd_digit: 4-bit register with en, up_dn, load and clear inputs; outputs the digit plus an at_max/at_min flag feeding the next digit's enable.
- Instantiated DIGITS times with a generate loop.

Test Plan (DIGITS=2, DIVIDE=4 unless noted):
- Reset mid-run at bcd=8'h37 -> all outputs 0 immediately without waiting for clk, state STOPPED.
- run_toggle, up_dn=1 from 00 -> tick every 4 cycles; 09->10 carry; 99->00 with terminal=1 on the same cycle (WRAP=1).
- WRAP=0, up_dn=0, load 8'h02, run -> 01, 00, then terminal=1, running=0, bcd holds 00; further run_toggle leaves the block in DONE.
- Pause after 2 prescaler cycles, wait 20 cycles, resume -> next tick 2 cycles after resume; bcd unchanged while paused.
- lap on the same cycle as the tick taking 41->42 -> lap_bcd=8'h41, bcd=8'h42.
- clear and load(8'h55) on the same cycle while running -> bcd=00, running=0; load_bcd=8'hFA -> bcd=8'h99 (clamped).
